pair_exit_arbiter: RTL and testbench
====================================

// Module: pair_exit_arbiter
// PURPOSE
//  Round-robin drain controller for NUM_SRC pair exit FIFOs (one per force pipeline).
//  Pops at most one 192-bit pair record per SLOT_PERIOD frame, only in the READ_SLOT phase,
//  and presents it to the single host readout port with a valid/ready handshake.
//  Sits between the per-pipeline exit FIFOs and the host DMA/readout logic.
// PARAMETERS
//  NUM_SRC      4    number of exit FIFOs served (1..16)
//  DATA_W       192  pair record width
//  SLOT_PERIOD  16   frame length in cycles; must match the FIFO slot counter
//  READ_SLOT    15   phase value in which a FIFO read is permitted
// PORTS
//  clk        in   1               clock
//  reset      in   1               reset, synchronous, active-high
//  enable     in   1               1 = new grants allowed; 0 = finish in-flight, no new reads
//  src_empty  in   NUM_SRC         per-FIFO empty flag
//  src_data   in   NUM_SRC*DATA_W  per-FIFO dout, source i at [i*DATA_W +: DATA_W]
//  src_rd     out  NUM_SRC         one-hot read strobe (registered)
//  out_data   out  DATA_W          captured pair record
//  out_src    out  4               index of source that out_data came from
//  out_valid  out  1               out_data/out_src valid
//  out_ready  in   1               host accepts when out_valid && out_ready
//  idle       out  1               1 = IDLE state, nothing in flight
//  xfer_count out  32              completed host handshakes, wraps at 2^32
// BEHAVIOUR
//  Reset: phase=SLOT_PERIOD-1, rr_ptr=0, state=IDLE; src_rd=0, out_valid=0, out_data=0,
//   out_src=0, idle=1, xfer_count=0. Phase counter free-runs 0..SLOT_PERIOD-1, wraps to 0.
//  States: IDLE -> READ -> CAPTURE -> HOLD -> IDLE.
//  IDLE: in the cycle phase==READ_SLOT-1 (mod SLOT_PERIOD), if enable=1 and any src_empty[i]=0:
//   g = first non-empty index searching rr_ptr, rr_ptr+1, ... mod NUM_SRC;
//   register src_rd[g]=1, latch g, go READ. Otherwise stay IDLE, rr_ptr unchanged.
//  READ: src_rd[g]=1 for exactly this one cycle (phase==READ_SLOT); rr_ptr <= (g+1) mod NUM_SRC; go CAPTURE.
//  CAPTURE: FIFO dout valid (1-cycle read latency); out_data <= src_data[g], out_src <= g,
//   out_valid <= 1; go HOLD. out_valid is first seen 2 cycles after the src_rd pulse.
//  HOLD: out_data/out_src stable while out_valid=1. On out_valid && out_ready: out_valid <= 0,
//   xfer_count <= xfer_count+1, go IDLE. Next grant no earlier than next frame's READ_SLOT-1.
//  Throughput: max one record per SLOT_PERIOD cycles; a HOLD spanning READ_SLOT-1 skips that frame.
//  src_rd is never asserted outside phase==READ_SLOT, never more than one bit, never while
//   out_valid=1.
//  enable falling mid-transfer: READ/CAPTURE/HOLD complete normally; no new grant after.
//  src_empty changing after the decision cycle is ignored for that grant.
//  idle=1 only in IDLE; deasserts the cycle src_rd rises.
//  Reset mid-operation: all state and outputs return to reset values at the next edge; a
//   record already popped but not handshaken is discarded (acceptable, reset flushes FIFOs).
// TESTING
//  1. Reset, all src_empty=1 for 64 cycles -> src_rd never set, idle=1, xfer_count=0.
//  2. Only src 2 non-empty, out_ready=1 -> src_rd=4'b0100 at cycles 15,31,47 after reset
//     release; out_valid 2 cycles after each pulse; out_src=2; out_data=src_data[2] at capture.
//  3. All sources non-empty, out_ready=1 -> grant order 0,1,2,3,0 in consecutive frames;
//     xfer_count=5 after 5 frames.
//  4. src 1 non-empty, out_ready=0 for 40 cycles -> out_valid held, data stable, no src_rd for
//     2 frames; raise out_ready -> one handshake, then src_rd=4'b0010 at next READ_SLOT.
//  5. enable=0 in READ cycle -> transfer completes (xfer_count +1), then no src_rd while enable=0.
//  6. Assert reset during HOLD -> next cycle out_valid=0, idle=1, rr_ptr=0, xfer_count=0.

Source files
------------

// File: rtl/pair_exit_arbiter_if.sv
// rtl/pair_exit_arbiter_if.sv - exit FIFO side and host readout side of the pair exit arbiter
interface pair_exit_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 192
);
  logic [NUM_SRC-1:0]        src_empty;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_rd;
  logic [DATA_W-1:0]         out_data;
  logic [3:0]                out_src;
  logic                      out_valid;
  logic                      out_ready;

  // master = the arbiter; slave = FIFOs plus host readout
  modport master (
    input  src_empty, src_data, out_ready,
    output src_rd, out_data, out_src, out_valid
  );

  modport slave (
    output src_empty, src_data, out_ready,
    input  src_rd, out_data, out_src, out_valid
  );
endinterface

// File: rtl/pair_exit_arbiter.sv
// rtl/pair_exit_arbiter.sv - round-robin drain of pair exit FIFOs, one record per slot frame
module pair_exit_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int DATA_W      = 192,
  parameter int SLOT_PERIOD = 16,
  parameter int READ_SLOT   = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  pair_exit_arbiter_if.master bus,
  output logic                idle,
  output logic [31:0]         xfer_count
);
  localparam int PH_W = (SLOT_PERIOD > 1) ? $clog2(SLOT_PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(SLOT_PERIOD - 1);
  // grant is decided one cycle early so the registered strobe lands on READ_SLOT
  localparam logic [PH_W-1:0] PH_DECIDE = PH_W'((READ_SLOT + SLOT_PERIOD - 1) % SLOT_PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPTURE, S_HOLD} state_t;

  state_t               state, state_n;
  logic [PH_W-1:0]      phase;
  logic [3:0]           rr_ptr, rr_ptr_n;
  logic [3:0]           grant, grant_n;
  logic [NUM_SRC-1:0]   src_rd_r, src_rd_n;
  logic [DATA_W-1:0]    out_data_r, out_data_n;
  logic [3:0]           out_src_r, out_src_n;
  logic                 out_valid_r, out_valid_n;
  logic [31:0]          xfer_r, xfer_n;
  logic                 found;
  logic [3:0]           pick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= PH_LAST;
      rr_ptr      <= '0;
      grant       <= '0;
      src_rd_r    <= '0;
      out_data_r  <= '0;
      out_src_r   <= '0;
      out_valid_r <= 1'b0;
      xfer_r      <= '0;
    end else begin
      state       <= state_n;
      phase       <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      rr_ptr      <= rr_ptr_n;
      grant       <= grant_n;
      src_rd_r    <= src_rd_n;
      out_data_r  <= out_data_n;
      out_src_r   <= out_src_n;
      out_valid_r <= out_valid_n;
      xfer_r      <= xfer_n;
    end
  end

  // first non-empty source at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && !bus.src_empty[(int'(rr_ptr) + k) % NUM_SRC]) begin
        found = 1'b1;
        pick  = 4'((int'(rr_ptr) + k) % NUM_SRC);
      end
    end
  end

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    grant_n     = grant;
    src_rd_n    = '0;
    out_data_n  = out_data_r;
    out_src_n   = out_src_r;
    out_valid_n = out_valid_r;
    xfer_n      = xfer_r;
    case (state)
      S_IDLE: begin
        if (phase == PH_DECIDE && enable && found) begin
          src_rd_n = NUM_SRC'(1) << pick;
          grant_n  = pick;
          state_n  = S_READ;
        end
      end
      S_READ: begin
        rr_ptr_n = 4'((int'(grant) + 1) % NUM_SRC);
        state_n  = S_CAPTURE;
      end
      S_CAPTURE: begin
        // FIFO dout reflects the pop one cycle after the strobe
        out_data_n  = bus.src_data[int'(grant) * DATA_W +: DATA_W];
        out_src_n   = grant;
        out_valid_n = 1'b1;
        state_n     = S_HOLD;
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_n = 1'b0;
          xfer_n      = xfer_r + 32'd1;
          state_n     = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.src_rd    = src_rd_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_src   = out_src_r;
  assign bus.out_valid = out_valid_r;
  assign idle          = (state == S_IDLE);
  assign xfer_count    = xfer_r;
endmodule

// File: tb/tb_pair_exit_arbiter.sv
// tb/tb_pair_exit_arbiter.sv - scoreboard bench for pair_exit_arbiter with a behavioural frame model
module tb_pair_exit_arbiter;
  typedef struct {
    logic [3:0]   src;
    logic [191:0] data;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        idle;
  logic [31:0] xfer_count;

  pair_exit_arbiter_if #(.NUM_SRC(4), .DATA_W(192)) bus ();

  pair_exit_arbiter #(.NUM_SRC(4), .DATA_W(192), .SLOT_PERIOD(16), .READ_SLOT(15)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus), .idle(idle), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          mph = 15, ms = 0, mg = 0, mrr = 0, cyc = -1;
  logic [31:0] mxfer = 0;
  int          cnt [4] = '{0, 0, 0, 0};
  rec_t        q [$];
  logic [3:0]  er;

  function automatic logic [191:0] pat(int s, int n);
    return {32'hA500_0000 | 32'(s), 32'(n), 32'(n * 7 + s), ~32'(n), 32'(s) * 32'h0101_0101, 32'(n) ^ 32'h5A5A_5A5A};
  endfunction

  // FIFO model: dout shows the next word once a pop has been seen
  always_comb for (int i = 0; i < 4; i++) bus.src_data[i*192 +: 192] = pat(i, cnt[i]);

  // advance one cycle and step the expected-behaviour model; pushes records at grant time
  task automatic tick();
    logic       pr, pe, prd;
    logic [3:0] pem;
    int         g;
    pr = reset; pe = enable; pem = bus.src_empty; prd = bus.out_ready;
    @(posedge clk);
    @(negedge clk);
    if (pr) begin
      mph = 15; ms = 0; mrr = 0; mxfer = 0; cyc = -1; q.delete();
    end else begin
      case (ms)
        0: if (mph == 14 && pe && pem != 4'hF) begin
          g = -1;
          for (int k = 0; k < 4; k++) if (g < 0 && !pem[(mrr + k) % 4]) g = (mrr + k) % 4;
          mg = g; ms = 1;
          q.push_back('{4'(g), pat(g, cnt[g] + 1)});
        end
        1: begin cnt[mg]++; mrr = (mg + 1) % 4; ms = 2; end
        2: ms = 3;
        default: if (prd) begin ms = 0; mxfer++; q.delete(0); end
      endcase
      mph = (mph + 1) % 16;
      cyc++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.src_empty = 4'hF; bus.out_ready = 1'b1; enable = 1'b1;
    do_reset();
    vectors += 3;
    if (bus.out_data !== 192'd0) begin miscompares++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    if (bus.out_src !== 4'd0) begin miscompares++; $display("FAIL rst_out_src: got %0d want 0", bus.out_src); end
    if (idle !== 1'b1 || bus.src_rd !== 4'b0) begin miscompares++; $display("FAIL rst_idle: got idle=%b rd=%b want 1/0000", idle, bus.src_rd); end
    for (int c = 0; c < 64; c++) begin
      vectors += 3;
      if (bus.src_rd !== 4'b0) begin miscompares++; $display("FAIL empty_rd cyc %0d: got %b want 0000", cyc, bus.src_rd); end
      if (idle !== 1'b1) begin miscompares++; $display("FAIL empty_idle cyc %0d: got %b want 1", cyc, idle); end
      if (xfer_count !== 32'd0) begin miscompares++; $display("FAIL empty_xfer: got %0d want 0", xfer_count); end
      tick();
    end
  endtask

  task automatic test_single();
    int pulses;
    pulses = 0;
    bus.src_empty = 4'b1011; bus.out_ready = 1'b1; enable = 1'b1;
    do_reset();
    for (int c = 0; c < 52; c++) begin
      er = (ms == 1) ? 4'(1 << mg) : 4'b0;
      vectors += 4;
      if (bus.src_rd !== er) begin miscompares++; $display("FAIL single_rd cyc %0d: got %b want %b", cyc, bus.src_rd, er); end
      if (bus.out_valid !== 1'(ms == 3)) begin miscompares++; $display("FAIL single_valid cyc %0d: got %b want %b", cyc, bus.out_valid, ms == 3); end
      if (idle !== 1'(ms == 0)) begin miscompares++; $display("FAIL single_idle cyc %0d: got %b want %b", cyc, idle, ms == 0); end
      if (xfer_count !== mxfer) begin miscompares++; $display("FAIL single_xfer: got %0d want %0d", xfer_count, mxfer); end
      if (ms == 3) begin
        vectors++;
        if ({bus.out_src, bus.out_data} !== {q[0].src, q[0].data}) begin miscompares++; $display("FAIL single_rec: got %0d/%h want %0d/%h", bus.out_src, bus.out_data, q[0].src, q[0].data); end
      end
      if (bus.src_rd !== 4'b0) begin
        vectors++;
        if (cyc != 15 + 16 * pulses) begin miscompares++; $display("FAIL single_timing: got cycle %0d want %0d", cyc, 15 + 16 * pulses); end
        pulses++;
      end
      tick();
    end
    vectors++;
    if (pulses != 3) begin miscompares++; $display("FAIL single_pulses: got %0d want 3", pulses); end
  endtask

  task automatic test_round_robin();
    int order [$];
    int want [5] = '{0, 1, 2, 3, 0};
    bus.src_empty = 4'b0000; bus.out_ready = 1'b1; enable = 1'b1;
    do_reset();
    for (int c = 0; c < 84; c++) begin
      er = (ms == 1) ? 4'(1 << mg) : 4'b0;
      vectors += 4;
      if (bus.src_rd !== er) begin miscompares++; $display("FAIL rr_rd cyc %0d: got %b want %b", cyc, bus.src_rd, er); end
      if (bus.out_valid !== 1'(ms == 3)) begin miscompares++; $display("FAIL rr_valid cyc %0d: got %b want %b", cyc, bus.out_valid, ms == 3); end
      if (idle !== 1'(ms == 0)) begin miscompares++; $display("FAIL rr_idle cyc %0d: got %b want %b", cyc, idle, ms == 0); end
      if (xfer_count !== mxfer) begin miscompares++; $display("FAIL rr_xfer: got %0d want %0d", xfer_count, mxfer); end
      if (ms == 3) begin
        vectors++;
        if ({bus.out_src, bus.out_data} !== {q[0].src, q[0].data}) begin miscompares++; $display("FAIL rr_rec: got %0d/%h want %0d/%h", bus.out_src, bus.out_data, q[0].src, q[0].data); end
      end
      for (int i = 0; i < 4; i++) if (bus.src_rd[i]) order.push_back(i);
      tick();
    end
    vectors += 2;
    if (xfer_count !== 32'd5) begin miscompares++; $display("FAIL rr_count: got %0d want 5", xfer_count); end
    if (order.size() != 5) begin miscompares++; $display("FAIL rr_grants: got %0d grants want 5", order.size()); end
    else for (int i = 0; i < 5; i++) begin
      vectors++;
      if (order[i] != want[i]) begin miscompares++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], want[i]); end
    end
  endtask

  task automatic test_backpressure();
    int waited;
    bus.src_empty = 4'b1101; bus.out_ready = 1'b0; enable = 1'b1;
    do_reset();
    waited = 0;
    while (ms != 3 && waited < 40) begin tick(); waited++; end
    vectors++;
    if (ms != 3) begin miscompares++; $display("FAIL bp_timeout: got no HOLD want HOLD within 40 cycles"); end
    for (int c = 0; c < 80; c++) begin
      if (c == 40) bus.out_ready = 1'b1;
      er = (ms == 1) ? 4'(1 << mg) : 4'b0;
      vectors += 4;
      if (bus.src_rd !== er) begin miscompares++; $display("FAIL bp_rd cyc %0d: got %b want %b", cyc, bus.src_rd, er); end
      if (bus.out_valid !== 1'(ms == 3)) begin miscompares++; $display("FAIL bp_valid cyc %0d: got %b want %b", cyc, bus.out_valid, ms == 3); end
      if (idle !== 1'(ms == 0)) begin miscompares++; $display("FAIL bp_idle cyc %0d: got %b want %b", cyc, idle, ms == 0); end
      if (xfer_count !== mxfer) begin miscompares++; $display("FAIL bp_xfer: got %0d want %0d", xfer_count, mxfer); end
      if (ms == 3) begin
        vectors++;
        if ({bus.out_src, bus.out_data} !== {q[0].src, q[0].data}) begin miscompares++; $display("FAIL bp_rec: got %0d/%h want %0d/%h", bus.out_src, bus.out_data, q[0].src, q[0].data); end
      end
      if (c < 40 && bus.src_rd !== 4'b0) begin vectors++; miscompares++; $display("FAIL bp_no_rd: got %b want 0000", bus.src_rd); end
      tick();
    end
    vectors++;
    if (xfer_count < 32'd1) begin miscompares++; $display("FAIL bp_count: got %0d want >=1", xfer_count); end
  endtask

  task automatic test_enable_drop();
    int waited;
    bus.src_empty = 4'b0000; bus.out_ready = 1'b1; enable = 1'b1;
    do_reset();
    waited = 0;
    while (ms != 1 && waited < 40) begin tick(); waited++; end
    vectors++;
    if (ms != 1) begin miscompares++; $display("FAIL en_timeout: got no READ want READ within 40 cycles"); end
    enable = 1'b0;
    for (int c = 0; c < 60; c++) begin
      er = (ms == 1) ? 4'(1 << mg) : 4'b0;
      vectors += 4;
      if (bus.src_rd !== er) begin miscompares++; $display("FAIL en_rd cyc %0d: got %b want %b", cyc, bus.src_rd, er); end
      if (bus.out_valid !== 1'(ms == 3)) begin miscompares++; $display("FAIL en_valid cyc %0d: got %b want %b", cyc, bus.out_valid, ms == 3); end
      if (idle !== 1'(ms == 0)) begin miscompares++; $display("FAIL en_idle cyc %0d: got %b want %b", cyc, idle, ms == 0); end
      if (xfer_count !== mxfer) begin miscompares++; $display("FAIL en_xfer: got %0d want %0d", xfer_count, mxfer); end
      if (ms == 3) begin
        vectors++;
        if ({bus.out_src, bus.out_data} !== {q[0].src, q[0].data}) begin miscompares++; $display("FAIL en_rec: got %0d/%h want %0d/%h", bus.out_src, bus.out_data, q[0].src, q[0].data); end
      end
      tick();
    end
    vectors++;
    if (xfer_count !== 32'd1) begin miscompares++; $display("FAIL en_count: got %0d want 1", xfer_count); end
    enable = 1'b1;
  endtask

  task automatic test_reset_hold();
    int waited;
    bus.src_empty = 4'b0000; bus.out_ready = 1'b1; enable = 1'b1;
    do_reset();
    waited = 0;
    while (mxfer != 1 && waited < 40) begin tick(); waited++; end
    bus.out_ready = 1'b0;
    while (ms != 3 && waited < 80) begin tick(); waited++; end
    vectors += 2;
    if (xfer_count !== 32'd1) begin miscompares++; $display("FAIL rh_pre_count: got %0d want 1", xfer_count); end
    if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL rh_pre_valid: got %b want 1", bus.out_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors += 4;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rh_valid: got %b want 0", bus.out_valid); end
    if (idle !== 1'b1) begin miscompares++; $display("FAIL rh_idle: got %b want 1", idle); end
    if (xfer_count !== 32'd0) begin miscompares++; $display("FAIL rh_count: got %0d want 0", xfer_count); end
    if (bus.out_src !== 4'd0) begin miscompares++; $display("FAIL rh_src: got %0d want 0", bus.out_src); end
    bus.out_ready = 1'b1;
    waited = 0;
    while (bus.src_rd === 4'b0 && waited < 40) begin tick(); waited++; end
    vectors++;
    if (bus.src_rd !== 4'b0001) begin miscompares++; $display("FAIL rh_first_grant: got %b want 0001", bus.src_rd); end
  endtask

  initial begin
    bus.src_empty = 4'hF;
    bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_enable_drop();
    test_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
